q2_counter_sched: RTL and testbench

- Round-robin scheduler that shares one 4-bit loadable up-counter (the Q2 datapath) between N requesters.
- Each requester asks for a count-up run from its own start value to a common terminal value.
- The scheduler loads the counter, watches its output, and signals completion or abort back to the requester.
- Sits between the requester logic and the counter's set/reset/init/out pins.

---
 rtl/q2_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/q2_counter_sched.sv | 129 ++++++++++++
 tb/tb_q2_counter_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/q2_sched_pkg.sv
// Shared types and defaults for the Q2 counter scheduler.
// The state enum is also used by benches to decode the debug state output.
package q2_sched_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] TERM_DEF = 4'hF;
  localparam int MAX_RUN_DEF = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } q2_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr_i,
// wrapping around the N requesters.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int cand;

  // Scan from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr_i) + off;
      if (cand >= N) cand = cand - N;
      if (req_i[cand]) begin
        pick_o       = '0;
        pick_o[cand] = 1'b1;
        idx_o        = IDX_W'(cand);
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/q2_counter_sched.sv
// Round-robin scheduler sharing one loadable 4-bit up-counter between N
// requesters; loads the counter, watches it reach TERM, reports done/abort.
module q2_counter_sched
  import q2_sched_pkg::*;
#(
  parameter int               N       = 4,
  parameter logic [CNT_W-1:0] TERM    = TERM_DEF,
  parameter int               MAX_RUN = MAX_RUN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [CNT_W*N-1:0] req_val,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic               abort,
  output logic               busy,
  output logic               cnt_set,
  output logic               cnt_reset,
  output logic [CNT_W-1:0]   cnt_init,
  input  logic [CNT_W-1:0]   cnt_out,
  output q2_state_e          dbg_state_o
);

  localparam int IDX_W = $clog2(N);
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  // Handshake: req[i] is a level held by requester i until it sees done[i] or
  // abort; gnt[i] pulses once in LOAD, and req[i] low during RUN withdraws it.

  q2_state_e          state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   val_q;
  logic [IDX_W-1:0]   rr_q;
  logic [RUN_W-1:0]   run_cnt_q;
  logic [N-1:0]       gnt_q, done_q;
  logic               abort_q, busy_q, cnt_set_q, cnt_reset_q;

  logic [N-1:0]       arb_pick;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [N-1:0]       idx_oh;
  logic [IDX_W-1:0]   rr_next;
  logic [CNT_W-1:0]   slot_val [N];

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot_val[i] = req_val[i*CNT_W +: CNT_W];
  end

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req_i   (req),
    .ptr_i   (rr_q),
    .pick_o  (arb_pick),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign idx_oh  = {{(N-1){1'b0}}, 1'b1} << idx_q;
  assign rr_next = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      val_q       <= '0;
      rr_q        <= '0;
      run_cnt_q   <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      cnt_set_q   <= 1'b0;
      cnt_reset_q <= 1'b0;
    end else begin
      // Strobes are single-cycle; each state transition re-arms the one it owns.
      gnt_q       <= '0;
      done_q      <= '0;
      abort_q     <= 1'b0;
      cnt_set_q   <= 1'b0;
      cnt_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            idx_q     <= arb_idx;
            val_q     <= slot_val[arb_idx];
            gnt_q     <= arb_pick;
            cnt_set_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          run_cnt_q <= '0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          run_cnt_q <= run_cnt_q + 1'b1;
          if (cnt_out == TERM) begin
            done_q  <= idx_oh;
            state_q <= S_DONE;
          end else if (!req[idx_q] || run_cnt_q == RUN_W'(MAX_RUN - 1)) begin
            abort_q     <= 1'b1;
            cnt_reset_q <= 1'b1;
            state_q     <= S_ABORT;
          end
        end
        S_DONE, S_ABORT: begin
          rr_q    <= rr_next;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign abort       = abort_q;
  assign busy        = busy_q;
  assign cnt_set     = cnt_set_q;
  assign cnt_reset   = cnt_reset_q;
  assign cnt_init    = val_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_q2_counter_sched.sv
// Bench for q2_counter_sched: behavioural Q2 counter, table-driven single runs,
// then async reset, round-robin fairness and withdrawal sequences.
module tb_q2_counter_sched;
  import q2_sched_pkg::*;

  localparam int N  = 4;
  localparam int EW = 2*N + 1;
  localparam logic [3:0] TERM = 4'hF;

  logic           clk, reset;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_val;
  logic [N-1:0]   gnt, done;
  logic           abort, busy, cnt_set, cnt_reset;
  logic [3:0]     cnt_init, cnt_q;
  q2_state_e      dbg_state;
  logic           stuck;

  int n_checks, n_fail;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_ev;
  logic          prev_busy;

  typedef struct {
    int         idx;
    logic [3:0] start;
    int         drop_at;
    bit         stuck;
    bit         exp_done;
    int         exp_lat;
  } vec_t;
  vec_t vecs[7];

  q2_counter_sched #(.N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .req_val(req_val),
    .gnt(gnt), .done(done), .abort(abort), .busy(busy),
    .cnt_set(cnt_set), .cnt_reset(cnt_reset), .cnt_init(cnt_init),
    .cnt_out(cnt_q), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Behavioural Q2 counter; 'stuck' freezes counting to exercise the watchdog.
  always @(posedge clk or posedge reset) begin
    if (reset)          cnt_q <= 4'd0;
    else if (cnt_set)   cnt_q <= cnt_init;
    else if (cnt_reset) cnt_q <= 4'd0;
    else if (!stuck)    cnt_q <= cnt_q + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [EW-1:0] ev_gnt(input int i);
    return {oh(i), {N{1'b0}}, 1'b0};
  endfunction

  function automatic logic [EW-1:0] ev_done(input int i);
    return {{N{1'b0}}, oh(i), 1'b0};
  endfunction

  function automatic logic [EW-1:0] ev_abort();
    return {{(2*N){1'b0}}, 1'b1};
  endfunction

  // gnt-to-done distance: LOAD, then k+1 RUN cycles, done shows in the next.
  function automatic int lat_done(input logic [3:0] s);
    logic [3:0] k;
    k = TERM - s;
    return int'(k) + 2;
  endfunction

  // scoreboard: every gnt/done/abort pulse must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && (gnt != '0 || done != '0 || abort)) begin
      mon_ev = {gnt, done, abort};
      if (exp_q.size() == 0) check("unexpected_event", 32'(mon_ev), 32'd0);
      else                   check("event", 32'(mon_ev), 32'(exp_q.pop_front()));
      if (gnt != '0) check("gnt_while_busy", 32'(prev_busy), 32'd0);
    end
    prev_busy = busy;
  end

  // driver tasks
  task automatic drive_req(input int idx, input logic [3:0] start);
    req_val[idx*4 +: 4] = start;
    req[idx] = 1'b1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_end(input int drop_idx, input int drop_at, output int lat);
    lat = 0;
    while (done == '0 && !abort && lat < 60) begin
      @(negedge clk);
      lat++;
      if (drop_at >= 0 && lat == drop_at) req[drop_idx] = 1'b0;
    end
  endtask

  int n, lat;
  int order[5];
  logic [3:0] rr_val[4];

  initial begin
    vecs[0] = '{0, 4'hC, -1, 1'b0, 1'b1, lat_done(4'hC)};
    vecs[1] = '{2, 4'hF, -1, 1'b0, 1'b1, lat_done(4'hF)};
    vecs[2] = '{1, 4'h0,  3, 1'b0, 1'b0, 4};
    vecs[3] = '{3, 4'h3, -1, 1'b1, 1'b0, MAX_RUN_DEF + 1};
    vecs[4] = '{0, 4'h0, -1, 1'b0, 1'b1, lat_done(4'h0)};
    vecs[5] = '{2, 4'hE,  1, 1'b0, 1'b0, 2};
    vecs[6] = '{0, 4'hE,  2, 1'b0, 1'b1, lat_done(4'hE)};
    order  = '{0, 1, 2, 3, 0};
    rr_val = '{4'hD, 4'hE, 4'hF, 4'hC};

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = '0;
    req_val  = '0;
    stuck    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt_set", 32'(cnt_set), 32'd0);
    check("rst_cnt_reset", 32'(cnt_reset), 32'd0);
    check("rst_cnt_init", 32'(cnt_init), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // table-driven single-requester runs
    for (int v = 0; v < 7; v++) begin
      exp_q.push_back(ev_gnt(vecs[v].idx));
      exp_q.push_back(vecs[v].exp_done ? ev_done(vecs[v].idx) : ev_abort());
      stuck = vecs[v].stuck;
      drive_req(vecs[v].idx, vecs[v].start);
      wait_gnt(n);
      check("gnt_lat", 32'(n), 32'd1);
      check("gnt_vec", 32'(gnt), 32'(oh(vecs[v].idx)));
      check("load_cnt_set", 32'(cnt_set), 32'd1);
      check("load_cnt_init", 32'(cnt_init), 32'(vecs[v].start));
      wait_end(vecs[v].idx, vecs[v].drop_at, lat);
      check("end_lat", 32'(lat), 32'(vecs[v].exp_lat));
      check("done_vec", 32'(done), vecs[v].exp_done ? 32'(oh(vecs[v].idx)) : 32'd0);
      check("abort_pulse", 32'(abort), 32'(!vecs[v].exp_done));
      check("cnt_reset_pulse", 32'(cnt_reset), 32'(!vecs[v].exp_done));
      check("end_busy", 32'(busy), 32'd1);
      req[vecs[v].idx] = 1'b0;
      stuck = 1'b0;
      @(negedge clk);
      check("post_busy", 32'(busy), 32'd0);
      check("post_state", 32'(dbg_state), 32'(S_IDLE));
      check("post_done", 32'({done, abort}), 32'd0);
    end

    // async reset in the middle of a run
    exp_q.push_back(ev_gnt(3));
    drive_req(3, 4'h0);
    wait_gnt(n);
    check("ar_gnt", 32'(gnt), 32'(oh(3)));
    repeat (3) @(negedge clk);
    check("ar_busy_run", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_outs", 32'({gnt, done, abort, cnt_set, cnt_reset}), 32'd0);
    check("ar_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);

    // round-robin with all requesters held; req[3] still asserted from before
    for (int g = 0; g < 5; g++) begin
      exp_q.push_back(ev_gnt(order[g]));
      exp_q.push_back(ev_done(order[g]));
    end
    for (int i = 0; i < 4; i++) drive_req(i, rr_val[i]);
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(n);
      check("rr_gap", 32'(n), (g == 0) ? 32'd1 : 32'd2);
      check("rr_gnt", 32'(gnt), 32'(oh(order[g])));
      wait_end(0, -1, lat);
      check("rr_done", 32'(done), 32'(oh(order[g])));
      check("rr_lat", 32'(lat), 32'(lat_done(rr_val[order[g]])));
      if (g == 4) req = '0;
    end
    @(negedge clk);

    // withdrawal: rr pointer is 1, so 1 wins; after abort, 3 beats lower 0
    exp_q.push_back(ev_gnt(1));
    exp_q.push_back(ev_abort());
    exp_q.push_back(ev_gnt(3));
    exp_q.push_back(ev_done(3));
    exp_q.push_back(ev_gnt(0));
    exp_q.push_back(ev_done(0));
    drive_req(0, 4'hF);
    drive_req(1, 4'h0);
    drive_req(3, 4'hF);
    wait_gnt(n);
    check("wd_gnt1", 32'(gnt), 32'(oh(1)));
    wait_end(1, 3, lat);
    check("wd_abort_lat", 32'(lat), 32'd4);
    check("wd_abort", 32'({abort, cnt_reset}), 32'd3);
    check("wd_no_done", 32'(done), 32'd0);
    wait_gnt(n);
    check("wd_gnt3", 32'(gnt), 32'(oh(3)));
    wait_end(0, -1, lat);
    check("wd_done3", 32'(done), 32'(oh(3)));
    req[3] = 1'b0;
    wait_gnt(n);
    check("wd_gnt0", 32'(gnt), 32'(oh(0)));
    wait_end(0, -1, lat);
    check("wd_done0", 32'(done), 32'(oh(0)));
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
